// File: rtl/uart_rx_frame_pkg.sv
`default_nettype none
// ============================================================================
// Package  : uart_pkg
// Summary  : Shared UART types, defaults and the parity helper used by TX and RX.
// Revision : 1.0
// ============================================================================
package uart_pkg;

    localparam int OVERSAMPLE_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // parity=1 selects the XOR of the data, parity=0 its complement.
    function automatic logic parity_bit(input logic [7:0] data, input logic parity);
        return parity ? (^data) : (~^data);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_bit.sv
`default_nettype none
// ============================================================================
// Module   : uart_sync_bit
// Summary  : N-stage single-bit synchroniser, preset to 1 on reset (idle-high lines).
// Revision : 1.0
// ============================================================================
module uart_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame
// Summary  : UART receive framer, 16x oversampled, one-entry holding register.
// Options  : UART_RX_MAJORITY_EN - 3-sample majority vote around each sample point
// Revision : 1.0
// ============================================================================
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = OVERSAMPLE_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk26m,
    input  logic       rst26m,
    input  logic       rx_bpsclk16,
    input  logic       urxd_i,
    input  logic       check,
    input  logic       parity,
    input  logic       rx_ready,
    input  logic       ovr_clr,
    output logic       rx_bpsen,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_perr,
    output logic       rx_ferr,
    output logic       rx_break,
    output logic       rx_overrun
);

    localparam int             CW          = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0]  C_MID_START = CW'(OVERSAMPLE/2 - 1);
    localparam logic [CW-1:0]  C_MID_BIT   = CW'(OVERSAMPLE - 1);

    uart_state_t   r_state;
    logic [CW-1:0] r_sample_cnt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shreg;
    logic          r_check;
    logic          r_parity;
    logic          r_perr;
    logic          r_rxs_d;
    logic          w_rxs;
    logic          w_fall;
    logic [CW-1:0] w_mid;
    logic          w_at_mid;
    logic          w_decide;
    logic          w_bit;

    uart_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk26m),
        .rst (rst26m),
        .d   (urxd_i),
        .q   (w_rxs)
    );

    assign w_fall   = r_rxs_d & ~w_rxs;
    assign w_mid    = (r_state == ST_START) ? C_MID_START : C_MID_BIT;
    assign w_at_mid = rx_bpsclk16 && (r_state != ST_IDLE) && (r_sample_cnt == w_mid);

`ifdef UART_RX_MAJORITY_EN
    // Counter clears at mid as usual; the vote completes one tick later.
    logic r_maj_a;
    logic r_maj_b;
    logic r_pend;

    assign w_decide = rx_bpsclk16 && r_pend;
    assign w_bit    = (r_maj_a & r_maj_b) | (r_maj_a & w_rxs) | (r_maj_b & w_rxs);

    always_ff @(posedge clk26m or posedge rst26m) begin
        if (rst26m) begin
            r_maj_a <= 1'b1;
            r_maj_b <= 1'b1;
            r_pend  <= 1'b0;
        end else if (rx_bpsclk16 && (r_state != ST_IDLE)) begin
            if (r_sample_cnt == (w_mid - CW'(1))) begin
                r_maj_a <= w_rxs;
            end
            if (w_at_mid) begin
                r_maj_b <= w_rxs;
                r_pend  <= 1'b1;
            end else if (r_pend) begin
                r_pend  <= 1'b0;
            end
        end else if (r_state == ST_IDLE) begin
            r_pend <= 1'b0;
        end
    end
`else
    assign w_decide = w_at_mid;
    assign w_bit    = w_rxs;
`endif

    always_ff @(posedge clk26m or posedge rst26m) begin
        if (rst26m) begin
            r_state      <= ST_IDLE;
            r_sample_cnt <= '0;
            r_bit_cnt    <= '0;
            r_shreg      <= '0;
            r_check      <= 1'b0;
            r_parity     <= 1'b0;
            r_perr       <= 1'b0;
            r_rxs_d      <= 1'b1;
            rx_bpsen     <= 1'b0;
            rx_valid     <= 1'b0;
            rx_data      <= '0;
            rx_perr      <= 1'b0;
            rx_ferr      <= 1'b0;
            rx_break     <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            r_rxs_d  <= w_rxs;
            rx_bpsen <= (r_state != ST_IDLE);

            if (ovr_clr) begin
                rx_overrun <= 1'b0;
            end
            // A commit in the STOP branch below overrides this pop.
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            if (rx_bpsclk16 && (r_state != ST_IDLE)) begin
                if (w_at_mid) begin
                    r_sample_cnt <= '0;
                end else begin
                    r_sample_cnt <= r_sample_cnt + CW'(1);
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_check      <= check;
                        r_parity     <= parity;
                        r_sample_cnt <= '0;
                        r_state      <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_decide) begin
                        if (!w_bit) begin
                            r_bit_cnt <= '0;
                            r_perr    <= 1'b0;
                            r_state   <= ST_DATA;
                        end else begin
                            r_state   <= ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_decide) begin
                        r_shreg[r_bit_cnt] <= w_bit;
                        r_bit_cnt          <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= r_check ? ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_decide) begin
                        r_perr  <= w_bit ^ parity_bit(r_shreg, r_parity);
                        r_state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_decide) begin
                        r_state <= ST_IDLE;
                        if (!rx_valid || rx_ready) begin
                            rx_valid <= 1'b1;
                            rx_data  <= r_shreg;
                            rx_perr  <= r_perr;
                            rx_ferr  <= ~w_bit;
                            rx_break <= ~w_bit & (r_shreg == 8'h00);
                        end else begin
                            rx_overrun <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_frame
// Summary  : Self-checking bench for uart_rx_frame (vector table, corner sequences, random frames).
// Revision : 1.0
// ============================================================================
module tb_uart_rx_frame;

    localparam int DIV = 4;
    localparam int OS  = 16;
`ifdef UART_RX_MAJORITY_EN
    localparam int COMMIT_IDX = OS/2 + 1;
`else
    localparam int COMMIT_IDX = OS/2;
`endif

    logic       clk26m = 1'b0;
    logic       rst26m = 1'b1;
    logic       rx_bpsclk16 = 1'b0;
    logic       urxd_i = 1'b1;
    logic       check = 1'b0;
    logic       parity = 1'b0;
    logic       rx_ready = 1'b0;
    logic       ovr_clr = 1'b0;
    logic       rx_bpsen;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_perr;
    logic       rx_ferr;
    logic       rx_break;
    logic       rx_overrun;

    int   n_checks = 0;
    int   n_errors = 0;
    logic v_before, v_after, lat_before, lat_after;

    uart_rx_frame dut (
        .clk26m      (clk26m),
        .rst26m      (rst26m),
        .rx_bpsclk16 (rx_bpsclk16),
        .urxd_i      (urxd_i),
        .check       (check),
        .parity      (parity),
        .rx_ready    (rx_ready),
        .ovr_clr     (ovr_clr),
        .rx_bpsen    (rx_bpsen),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_perr     (rx_perr),
        .rx_ferr     (rx_ferr),
        .rx_break    (rx_break),
        .rx_overrun  (rx_overrun)
    );

    always #5 clk26m = ~clk26m;

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] d;
        logic       chk;
        logic       par;
        logic       pbit;
        logic       stop;
        logic [7:0] e_d;
        logic       e_perr;
        logic       e_ferr;
        logic       e_brk;
    } vec_t;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One oversample tick period; line/ready/clear are applied in the tick cycle.
    task automatic one_tick(input logic line, input logic rdy, input logic clr);
        @(negedge clk26m);
        urxd_i = line; rx_bpsclk16 = 1'b1; rx_ready = rdy; ovr_clr = clr;
        v_before = rx_valid;
        @(negedge clk26m);
        rx_bpsclk16 = 1'b0; rx_ready = 1'b0; ovr_clr = 1'b0;
        v_after = rx_valid;
        repeat (DIV-2) @(negedge clk26m);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) one_tick(1'b1, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic chk_en, input logic pbit,
                              input logic stop, input logic rdy_c, input logic clr_c);
        logic [10:0] bits;
        int nb;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = d;
        if (chk_en) begin bits[9] = pbit; bits[10] = stop; nb = 11; end
        else        begin bits[9] = stop; nb = 10; end
        for (int b = 0; b < nb; b++) begin
            for (int t = 0; t < OS; t++) begin
                if (b == 1 && t == 0) begin
                    check  = 1'($urandom);
                    parity = 1'($urandom);
                end
                if (b == nb-1 && t == COMMIT_IDX) begin
                    one_tick(bits[b], rdy_c, clr_c);
                    lat_before = v_before;
                    lat_after  = v_after;
                end else begin
                    one_tick(bits[b], 1'b0, 1'b0);
                end
            end
        end
    endtask

    function automatic logic exp_par(input logic [7:0] d, input logic p);
        int ones;
        ones = $countones(d);
        return p ? ((ones % 2) == 1) : ((ones % 2) == 0);
    endfunction

    vec_t tbl[8];
    logic       m_valid, m_ovr, m_perr, m_ferr, m_brk;
    logic [7:0] m_data;

    initial begin
        tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{8'h03, 1'b1, 1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};

        repeat (3) @(negedge clk26m);
        chk("reset rx_valid",   rx_valid,   1'b0);
        chk("reset rx_data",    rx_data,    8'h00);
        chk("reset rx_perr",    rx_perr,    1'b0);
        chk("reset rx_ferr",    rx_ferr,    1'b0);
        chk("reset rx_break",   rx_break,   1'b0);
        chk("reset rx_overrun", rx_overrun, 1'b0);
        chk("reset rx_bpsen",   rx_bpsen,   1'b0);
        rst26m = 1'b0;
        idle(3);
        chk("idle rx_valid", rx_valid, 1'b0);

        for (int i = 0; i < 8; i++) begin
            check = tbl[i].chk; parity = tbl[i].par;
            send_frame(tbl[i].d, tbl[i].chk, tbl[i].pbit, tbl[i].stop, 1'b0, 1'b0);
            if (i == 0) begin
                chk("latency valid before commit tick", lat_before, 1'b0);
                chk("latency valid after commit tick",  lat_after,  1'b1);
            end
            chk("tbl rx_valid", rx_valid, 1'b1);
            chk("tbl rx_data",  rx_data,  tbl[i].e_d);
            chk("tbl rx_perr",  rx_perr,  tbl[i].e_perr);
            chk("tbl rx_ferr",  rx_ferr,  tbl[i].e_ferr);
            chk("tbl rx_break", rx_break, tbl[i].e_brk);
            one_tick(1'b1, 1'b1, 1'b0);
            chk("tbl pop rx_valid", rx_valid, 1'b0);
            idle(1);
        end

        // Short low glitch: false start, back to idle.
        for (int t = 0; t < 6; t++) begin
            one_tick(1'b0, 1'b0, 1'b0);
            if (t == 3) chk("glitch rx_bpsen high", rx_bpsen, 1'b1);
        end
        idle(14);
        chk("glitch rx_bpsen low", rx_bpsen, 1'b0);
        chk("glitch rx_valid",     rx_valid, 1'b0);

        // Back-to-back frames without popping.
        check = 1'b0; parity = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check = 1'b0;
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check = 1'b0;
        send_frame(8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("b2b rx_data",    rx_data,    8'h11);
        chk("b2b rx_overrun", rx_overrun, 1'b1);
        one_tick(1'b1, 1'b0, 1'b1);
        chk("ovr_clr rx_overrun", rx_overrun, 1'b0);
        check = 1'b0;
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("commit+pop rx_data",    rx_data,    8'h22);
        chk("commit+pop rx_valid",   rx_valid,   1'b1);
        chk("commit+pop rx_overrun", rx_overrun, 1'b0);
        one_tick(1'b1, 1'b1, 1'b0);

        // Overrun set and ovr_clr in the same cycle: set wins.
        check = 1'b0;
        send_frame(8'h44, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check = 1'b0;
        send_frame(8'h66, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("set-wins rx_overrun", rx_overrun, 1'b1);
        chk("set-wins rx_data",    rx_data,    8'h44);
        one_tick(1'b1, 1'b1, 1'b1);
        chk("clear rx_overrun", rx_overrun, 1'b0);
        chk("clear rx_valid",   rx_valid,   1'b0);
        idle(1);

        // Randomised frames against the holding-register model.
        m_valid = 1'b0; m_ovr = 1'b0; m_data = 8'h00;
        m_perr = 1'b0; m_ferr = 1'b0; m_brk = 1'b0;
        for (int i = 0; i < 30; i++) begin
            logic [7:0] d;
            logic c, p, s, good, pb, rc;
            d = 8'($urandom); c = 1'($urandom); p = 1'($urandom);
            s = ($urandom_range(0, 3) != 0);
            good = ($urandom_range(0, 2) != 0);
            pb = c ? (exp_par(d, p) ^ ~good) : 1'b0;
            rc = 1'($urandom);
            check = c; parity = p;
            send_frame(d, c, pb, s, rc, 1'b0);
            if (!m_valid || rc) begin
                m_valid = 1'b1; m_data = d;
                m_perr = c && (pb != exp_par(d, p));
                m_ferr = !s;
                m_brk  = !s && (d == 8'h00);
            end else begin
                m_ovr = 1'b1;
            end
            chk("rnd rx_valid",   rx_valid,   m_valid);
            chk("rnd rx_overrun", rx_overrun, m_ovr);
            chk("rnd rx_data",    rx_data,    m_data);
            chk("rnd rx_perr",    rx_perr,    m_perr);
            chk("rnd rx_ferr",    rx_ferr,    m_ferr);
            chk("rnd rx_break",   rx_break,   m_brk);
            if ($urandom_range(0, 1) == 1) begin one_tick(1'b1, 1'b1, 1'b0); m_valid = 1'b0; end
            if ($urandom_range(0, 3) == 0) begin one_tick(1'b1, 1'b0, 1'b1); m_ovr = 1'b0; end
            idle(1);
        end

        // Reset during DATA bit 4 with a byte held and overrun forced.
        check = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h5B, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int t = 0; t < OS; t++) one_tick(1'b0, 1'b0, 1'b0);
        for (int b = 0; b < 4; b++)
            for (int t = 0; t < OS; t++) one_tick(b[0], 1'b0, 1'b0);
        for (int t = 0; t < OS/2; t++) one_tick(1'b0, 1'b0, 1'b0);
        @(negedge clk26m);
        rst26m = 1'b1; urxd_i = 1'b1;
        @(negedge clk26m);
        chk("midreset rx_valid",   rx_valid,   1'b0);
        chk("midreset rx_data",    rx_data,    8'h00);
        chk("midreset rx_ferr",    rx_ferr,    1'b0);
        chk("midreset rx_overrun", rx_overrun, 1'b0);
        chk("midreset rx_bpsen",   rx_bpsen,   1'b0);
        rst26m = 1'b0;
        idle(OS);
        chk("post-reset rx_valid", rx_valid, 1'b0);
        check = 1'b0;
        send_frame(8'h7E, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("post-reset rx_data",  rx_data,  8'h7E);
        chk("post-reset rx_valid", rx_valid, 1'b1);
        chk("post-reset rx_ferr",  rx_ferr,  1'b0);
        one_tick(1'b1, 1'b1, 1'b0);
        idle(1);

`ifdef UART_RX_MAJORITY_EN
        // One-tick spike at the sample point of data bit 2 of 0x00.
        check = 1'b0;
        for (int b = 0; b < 10; b++)
            for (int t = 0; t < OS; t++)
                one_tick((b == 9) || (b == 3 && t == OS/2 - 1), 1'b0, 1'b0);
        chk("majority spike rx_data", rx_data,  8'h00);
        chk("majority spike rx_ferr", rx_ferr,  1'b0);
        one_tick(1'b1, 1'b1, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
